// File: rtl/decode_mc.sv
// Multicycle ARM-subset control unit: main FSM, ALU decoder, PC logic, instruction decoder.
// DECODE_MUL_EN builds the multi-cycle multiply path (MULEX/MULWB, latency counter, MulStart, Busy).
module decode_mc #(
  parameter int          ALUCTL_W = 3,
  parameter int          MUL_LAT  = 4,
  parameter logic [3:0]  MUL_CMD  = 4'b1011
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          i_Op,
  input  logic [5:0]          i_Funct,
  input  logic [3:0]          i_Rd,
  output logic [1:0]          o_FlagW,
  output logic                o_PCS,
  output logic                o_NextPC,
  output logic                o_RegW,
  output logic                o_MemW,
  output logic                o_IRWrite,
  output logic                o_AdrSrc,
  output logic [1:0]          o_ResultSrc,
  output logic [1:0]          o_ALUSrcA,
  output logic [1:0]          o_ALUSrcB,
  output logic [1:0]          o_ImmSrc,
  output logic [1:0]          o_RegSrc,
  output logic [ALUCTL_W-1:0] o_ALUControl,
  output logic                o_MulStart,
  output logic                o_Busy
);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    EXECUTER, EXECUTEI, ALUWB, BRANCH, MULEX, MULWB
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [3:0] w_cmd;
  logic       w_i;
  logic       w_s;
  logic       w_is_mul;
  logic       w_cnt_zero;
  logic       w_cnt_last;

  assign w_cmd = i_Funct[4:1];
  assign w_i   = i_Funct[5];
  assign w_s   = i_Funct[0];

`ifdef DECODE_MUL_EN
  localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  logic [CNT_W-1:0] r_cnt;

  assign w_is_mul   = (w_cmd == MUL_CMD);
  assign w_cnt_zero = (r_cnt == '0);
  assign w_cnt_last = (r_cnt == CNT_W'(MUL_LAT - 1));

  // Counter runs only while staying in MULEX, so every entry starts at 0
  always_ff @(posedge clk) begin
    if (reset)
      r_cnt <= '0;
    else if (r_state == MULEX && w_next == MULEX)
      r_cnt <= r_cnt + 1'b1;
    else
      r_cnt <= '0;
  end
`else
  logic [31:0] w_unused_lat;

  assign w_unused_lat = 32'(MUL_LAT);
  assign w_is_mul     = 1'b0;
  assign w_cnt_zero   = 1'b0;
  assign w_cnt_last   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset)
      r_state <= FETCH;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      FETCH:  w_next = DECODE;
      DECODE: begin
        unique case (1'b1)
          (i_Op == 2'b01):                    w_next = MEMADR;
          (i_Op == 2'b10):                    w_next = BRANCH;
          (i_Op == 2'b11):                    w_next = FETCH;
          (i_Op == 2'b00 && w_i):             w_next = EXECUTEI;
          (i_Op == 2'b00 && !w_i && w_is_mul):  w_next = MULEX;
          (i_Op == 2'b00 && !w_i && !w_is_mul): w_next = EXECUTER;
          default:                            w_next = FETCH;
        endcase
      end
      MEMADR:   w_next = w_s ? MEMRD : MEMWR;
      MEMRD:    w_next = MEMWB;
      EXECUTER: w_next = ALUWB;
      EXECUTEI: w_next = ALUWB;
`ifdef DECODE_MUL_EN
      MULEX:    w_next = w_cnt_last ? MULWB : MULEX;
`endif
      default:  w_next = FETCH;
    endcase
  end

  logic [2:0] w_ctl;
  logic [1:0] w_fl;
  logic       w_valid;

  always_comb begin
    w_ctl   = 3'b000;
    w_fl    = 2'b00;
    w_valid = 1'b1;
    case (w_cmd)
      4'b0100: begin w_ctl = 3'b000; w_fl = {w_s, w_s}; end
      4'b0010: begin w_ctl = 3'b001; w_fl = {w_s, w_s}; end
      4'b0000: begin w_ctl = 3'b010; w_fl = {w_s, 1'b0}; end
      4'b1100: begin w_ctl = 3'b011; w_fl = {w_s, 1'b0}; end
      default: begin
        if (w_is_mul) w_ctl = 3'b110;
        else          w_valid = 1'b0;
      end
    endcase
  end

  logic w_aluop;
  logic w_regw;
  logic w_branch;
  logic w_memw;
  logic w_irw;
  logic w_npc;
  logic w_start;
  logic w_busy;

  always_comb begin
    w_aluop     = 1'b0;
    w_regw      = 1'b0;
    w_branch    = 1'b0;
    w_memw      = 1'b0;
    w_irw       = 1'b0;
    w_npc       = 1'b0;
    w_start     = 1'b0;
    w_busy      = 1'b0;
    o_AdrSrc    = 1'b0;
    o_ResultSrc = 2'b00;
    o_ALUSrcA   = 2'b00;
    o_ALUSrcB   = 2'b00;
    unique case (r_state)
      FETCH: begin
        w_irw       = 1'b1;
        w_npc       = 1'b1;
        o_ALUSrcA   = 2'b01;
        o_ALUSrcB   = 2'b10;
        o_ResultSrc = 2'b10;
      end
      DECODE: begin
        o_ALUSrcA   = 2'b01;
        o_ALUSrcB   = 2'b10;
        o_ResultSrc = 2'b10;
      end
      MEMADR:   o_ALUSrcB = 2'b01;
      MEMRD:    o_AdrSrc  = 1'b1;
      MEMWB: begin
        o_ResultSrc = 2'b01;
        w_regw      = 1'b1;
      end
      MEMWR: begin
        o_AdrSrc = 1'b1;
        w_memw   = 1'b1;
      end
      EXECUTER: w_aluop = 1'b1;
      EXECUTEI: begin
        o_ALUSrcB = 2'b01;
        w_aluop   = 1'b1;
      end
      // Unimplemented commands execute as a no-op with no writeback
      ALUWB:    w_regw = w_valid;
      BRANCH: begin
        o_ALUSrcB   = 2'b01;
        o_ResultSrc = 2'b10;
        w_branch    = 1'b1;
      end
`ifdef DECODE_MUL_EN
      MULEX: begin
        w_aluop = 1'b1;
        w_busy  = 1'b1;
        w_start = w_cnt_zero;
      end
      MULWB:    w_regw = 1'b1;
`endif
      default: ;
    endcase
  end

  always_comb begin
    o_ALUControl      = '0;
    o_ALUControl[2:0] = w_aluop ? w_ctl : 3'b000;
  end

  assign o_FlagW    = (w_aluop && !reset) ? w_fl : 2'b00;
  assign o_RegW     = w_regw & !reset;
  assign o_MemW     = w_memw & !reset;
  assign o_IRWrite  = w_irw & !reset;
  assign o_NextPC   = w_npc & !reset;
  assign o_MulStart = w_start & !reset;
  assign o_Busy     = w_busy & !reset;
  assign o_PCS      = !reset & (((i_Rd == 4'd15) & w_regw) | w_branch);
  assign o_ImmSrc   = i_Op;
  assign o_RegSrc   = {i_Op == 2'b01, i_Op == 2'b10};

endmodule

// File: tb/tb_decode_mc.sv
// Randomised bench for decode_mc: per-instruction expected cycle traces built from the
// instruction-level rules, compared cycle by cycle against every control output.
module tb_decode_mc;

  localparam int         LAT  = 4;
  localparam logic [3:0] MCMD = 4'b1011;
`ifdef DECODE_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic [1:0] i_Op;
  logic [5:0] i_Funct;
  logic [3:0] i_Rd;
  logic [1:0] o_FlagW;
  logic       o_PCS, o_NextPC, o_RegW, o_MemW, o_IRWrite, o_AdrSrc;
  logic [1:0] o_ResultSrc, o_ALUSrcA, o_ALUSrcB, o_ImmSrc, o_RegSrc;
  logic [2:0] o_ALUControl;
  logic       o_MulStart, o_Busy;

  decode_mc #(.ALUCTL_W(3), .MUL_LAT(LAT), .MUL_CMD(MCMD)) dut (
    .clk(clk), .reset(reset), .i_Op(i_Op), .i_Funct(i_Funct), .i_Rd(i_Rd),
    .o_FlagW(o_FlagW), .o_PCS(o_PCS), .o_NextPC(o_NextPC), .o_RegW(o_RegW),
    .o_MemW(o_MemW), .o_IRWrite(o_IRWrite), .o_AdrSrc(o_AdrSrc),
    .o_ResultSrc(o_ResultSrc), .o_ALUSrcA(o_ALUSrcA), .o_ALUSrcB(o_ALUSrcB),
    .o_ImmSrc(o_ImmSrc), .o_RegSrc(o_RegSrc), .o_ALUControl(o_ALUControl),
    .o_MulStart(o_MulStart), .o_Busy(o_Busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] flagw;
    logic       pcs, nextpc, regw, memw, irwrite, adrsrc;
    logic [1:0] resultsrc, alusrca, alusrcb, immsrc, regsrc;
    logic [2:0] aluctl;
    logic       mulstart, busy;
  } rec_t;

  rec_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  function automatic rec_t act();
    rec_t r;
    r.flagw = o_FlagW; r.pcs = o_PCS; r.nextpc = o_NextPC; r.regw = o_RegW;
    r.memw = o_MemW; r.irwrite = o_IRWrite; r.adrsrc = o_AdrSrc;
    r.resultsrc = o_ResultSrc; r.alusrca = o_ALUSrcA; r.alusrcb = o_ALUSrcB;
    r.immsrc = o_ImmSrc; r.regsrc = o_RegSrc; r.aluctl = o_ALUControl;
    r.mulstart = o_MulStart; r.busy = o_Busy;
    return r;
  endfunction

  function automatic rec_t blank(input logic [1:0] op);
    rec_t r = '0;
    r.immsrc = op;
    r.regsrc = {op == 2'b01, op == 2'b10};
    return r;
  endfunction

  function automatic void alu_ref(input logic [3:0] cmd, input logic s,
                                  output logic [2:0] ctl, output logic [1:0] fl,
                                  output logic ok);
    ok = 1'b1; ctl = 3'd0; fl = 2'd0;
    if      (cmd == 4'b0100) begin ctl = 3'd0; fl = {s, s}; end
    else if (cmd == 4'b0010) begin ctl = 3'd1; fl = {s, s}; end
    else if (cmd == 4'b0000) begin ctl = 3'd2; fl = {s, 1'b0}; end
    else if (cmd == 4'b1100) begin ctl = 3'd3; fl = {s, 1'b0}; end
    else if (cmd == MCMD && MUL_EN) ctl = 3'd6;
    else ok = 1'b0;
  endfunction

  // Expected per-cycle outputs of one instruction, from FETCH to its last cycle
  task automatic build(input logic [1:0] op, input logic [5:0] fn, input logic [3:0] rd);
    rec_t r;
    logic [2:0] ctl;
    logic [1:0] fl;
    logic ok;
    exp_q.delete();
    r = blank(op); r.irwrite = 1; r.nextpc = 1;
    r.alusrca = 2'd1; r.alusrcb = 2'd2; r.resultsrc = 2'd2; exp_q.push_back(r);
    r = blank(op); r.alusrca = 2'd1; r.alusrcb = 2'd2; r.resultsrc = 2'd2;
    exp_q.push_back(r);
    if (op == 2'b01) begin
      r = blank(op); r.alusrcb = 2'd1; exp_q.push_back(r);
      if (fn[0]) begin
        r = blank(op); r.adrsrc = 1; exp_q.push_back(r);
        r = blank(op); r.resultsrc = 2'd1; r.regw = 1; exp_q.push_back(r);
      end else begin
        r = blank(op); r.adrsrc = 1; r.memw = 1; exp_q.push_back(r);
      end
    end else if (op == 2'b10) begin
      r = blank(op); r.alusrcb = 2'd1; r.resultsrc = 2'd2; r.pcs = 1;
      exp_q.push_back(r);
    end else if (op == 2'b00) begin
      if (!fn[5] && fn[4:1] == MCMD && MUL_EN) begin
        for (int k = 0; k < LAT; k++) begin
          r = blank(op); r.aluctl = 3'd6; r.busy = 1; r.mulstart = (k == 0);
          exp_q.push_back(r);
        end
        r = blank(op); r.regw = 1; exp_q.push_back(r);
      end else begin
        alu_ref(fn[4:1], fn[0], ctl, fl, ok);
        r = blank(op); r.alusrcb = fn[5] ? 2'd1 : 2'd0;
        r.aluctl = ctl; r.flagw = fl; exp_q.push_back(r);
        r = blank(op); r.regw = ok; exp_q.push_back(r);
      end
    end
    foreach (exp_q[i])
      if (exp_q[i].regw && rd == 4'd15) exp_q[i].pcs = 1'b1;
  endtask

  // Entered just after a negedge with the DUT in FETCH; returns the same way
  task automatic run_instr(input logic [1:0] op, input logic [5:0] fn,
                           input logic [3:0] rd, input string nm, input int abort_at);
    rec_t a;
    i_Op = op; i_Funct = fn; i_Rd = rd;
    build(op, fn, rd);
    #1;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i == abort_at) begin
        reset = 1'b1;
        #1;
        n_chk++;
        if ({o_IRWrite, o_NextPC, o_RegW, o_MemW, o_PCS, o_MulStart, o_Busy, o_FlagW} !== 9'd0)
          $display("FAIL %s abort_forced: got %b required 0", nm,
                   {o_IRWrite, o_NextPC, o_RegW, o_MemW, o_PCS, o_MulStart, o_Busy, o_FlagW});
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        #1;
        a = act();
        n_chk++;
        if (a !== exp_q[0])
          $display("FAIL %s after_abort: got %h required %h", nm, a, exp_q[0]);
        else n_pass++;
        return;
      end
      a = act();
      n_chk++;
      if (a !== exp_q[i])
        $display("FAIL %s cyc%0d op=%b fn=%b rd=%0d: got %h required %h",
                 nm, i, op, fn, rd, a, exp_q[i]);
      else n_pass++;
      @(negedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; i_Op = 2'b00; i_Funct = 6'b001001; i_Rd = 4'd3;
    @(negedge clk);
    for (int c = 0; c < 2; c++) begin
      #1;
      n_chk++;
      if ({o_IRWrite, o_NextPC, o_RegW, o_MemW, o_PCS, o_MulStart, o_Busy, o_FlagW} !== 9'd0)
        $display("FAIL reset_forced%0d: got %b required 0", c,
                 {o_IRWrite, o_NextPC, o_RegW, o_MemW, o_PCS, o_MulStart, o_Busy, o_FlagW});
      else n_pass++;
      @(negedge clk);
    end
    reset = 1'b0;
    run_instr(2'b00, 6'b001001, 4'd3, "reset_add", -1);
  endtask

  task automatic test_alu();
    run_instr(2'b00, 6'b000101, 4'd2, "sub_s", -1);
    run_instr(2'b00, 6'b011001, 4'd7, "orr_s", -1);
    run_instr(2'b00, 6'b000000, 4'd1, "and", -1);
    run_instr(2'b00, 6'b101001, 4'd15, "addi_pc", -1);
    run_instr(2'b00, 6'b011111, 4'd4, "bad_cmd", -1);
  endtask

  task automatic test_mem();
    run_instr(2'b01, 6'b000001, 4'd15, "ldr_pc", -1);
    run_instr(2'b01, 6'b100000, 4'd4, "str", -1);
    run_instr(2'b01, 6'b110001, 4'd3, "ldr", -1);
  endtask

  task automatic test_branch();
    run_instr(2'b10, 6'($urandom), 4'($urandom), "branch", -1);
    run_instr(2'b11, 6'($urandom), 4'd15, "op11", -1);
  endtask

  task automatic test_mul();
    run_instr(2'b00, 6'b010111, 4'd5, "mul", -1);
    run_instr(2'b00, 6'b010110, 4'd15, "mul_pc", -1);
  endtask

  task automatic test_mul_reset();
    run_instr(2'b00, 6'b010111, 4'd6, "mul_abort", 3);
    run_instr(2'b00, 6'b010111, 4'd6, "mul_after_abort", -1);
  endtask

  task automatic test_cycle_counts();
    logic [1:0] ops[6] = '{2'b10, 2'b00, 2'b01, 2'b01, 2'b00, 2'b11};
    logic [5:0] fns[6] = '{6'b000000, 6'b001000, 6'b000000, 6'b000001,
                           6'b010110, 6'b000000};
    int lens[6];
    int cnt;
    lens = '{3, 4, 4, 5, MUL_EN ? LAT + 3 : 4, 2};
    for (int t = 0; t < 6; t++) begin
      i_Op = ops[t]; i_Funct = fns[t]; i_Rd = 4'd2;
      cnt = 0;
      do begin
        @(negedge clk);
        #1;
        cnt++;
      end while (!o_IRWrite && cnt < 50);
      n_chk++;
      if (cnt != lens[t])
        $display("FAIL cycles_op%b_fn%b: got %0d required %0d", ops[t], fns[t], cnt, lens[t]);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] op;
    logic [5:0] fn;
    logic [3:0] rd;
    for (int n = 0; n < 60; n++) begin
      op = 2'($urandom_range(0, 3));
      fn = 6'($urandom);
      rd = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom);
      if ($urandom_range(0, 4) == 0) begin
        op = 2'b00;
        fn = {1'b0, MCMD, 1'($urandom)};
      end
      run_instr(op, fn, rd, "random", -1);
    end
  endtask

  initial begin
    reset = 1'b1; i_Op = '0; i_Funct = '0; i_Rd = '0;
    test_reset();
    test_alu();
    test_mem();
    test_branch();
    test_mul();
    test_mul_reset();
    test_cycle_counts();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
